mem_arbiter: RTL and testbench

Shared data-memory arbiter directly downstream of the CPU memory stage: accepts word requests from three masters (CPU memory stage, accelerator, DMA), grants one at a time by round-robin, and performs the access on an internal single-port synchronous RAM. Each master receives a one-cycle valid pulse with read data. The CPU memory stage stalls on `CPUValid`.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/arb_sram.sv | 29 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin winner function for the three-master
// data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} arb_state_t;
  typedef enum logic [1:0] {M_CPU, M_ACL, M_DMA} master_t;

  localparam int NUM_MASTERS = 3;

  // Search starts at the master after 'last' and wraps CPU -> Acl -> DMA -> CPU.
  // req bit order: [0]=CPU, [1]=Acl, [2]=DMA. With no request, 'last' is returned.
  function automatic master_t rr_next(master_t last, logic [2:0] req);
    master_t win;
    win = last;
    unique case (last)
      M_CPU: begin
        if (req[1])      win = M_ACL;
        else if (req[2]) win = M_DMA;
        else if (req[0]) win = M_CPU;
      end
      M_ACL: begin
        if (req[2])      win = M_DMA;
        else if (req[0]) win = M_CPU;
        else if (req[1]) win = M_ACL;
      end
      default: begin
        if (req[0])      win = M_CPU;
        else if (req[1]) win = M_ACL;
        else if (req[2]) win = M_DMA;
      end
    endcase
    return win;
  endfunction

endpackage

// File: rtl/arb_sram.sv
// Single-port synchronous RAM with registered read and write-first behaviour;
// the array is deliberately left unreset so it maps onto block RAM.
module arb_sram #(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  dout
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= din;
        dout        <= din;
      end else begin
        dout <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the CPU memory stage, accelerator and DMA
// one-at-a-time word access to a shared RAM; one transaction per 3 cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         CPUEn,
  input  logic         AclEn,
  input  logic         DMAEn,
  input  logic         CPUWrEn,
  input  logic         AclWrEn,
  input  logic         DMAWrEn,
  input  logic [N-1:0] CPUAddr,
  input  logic [N-1:0] AclAddr,
  input  logic [N-1:0] DMAAddr,
  input  logic [N-1:0] CPUData,
  input  logic [N-1:0] AclData,
  input  logic [N-1:0] DMAData,
  output logic [N-1:0] CPUOut,
  output logic [N-1:0] AclOut,
  output logic [N-1:0] DMAOut,
  output logic         CPUValid,
  output logic         AclValid,
  output logic         DMAValid,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);

  arb_state_t   r_state;
  master_t      r_last;
  master_t      r_win;
  logic         r_we;
  logic [AW-1:0] r_idx;
  logic [N-1:0] r_data;
  logic [N-1:0] r_out [NUM_MASTERS];
  logic [2:0]   r_valid;

  logic [2:0]   w_req;
  master_t      w_sel;
  logic         w_sel_we;
  logic [N-1:0] w_sel_addr;
  logic [N-1:0] w_sel_data;
  logic [N-1:0] w_ram_dout;
  logic         w_ram_en;
  logic         w_unused;

  assign w_req = {DMAEn, AclEn, CPUEn};
  assign w_sel = rr_next(r_last, w_req);

  always_comb begin
    w_sel_we   = CPUWrEn;
    w_sel_addr = CPUAddr;
    w_sel_data = CPUData;
    unique case (w_sel)
      M_ACL: begin
        w_sel_we   = AclWrEn;
        w_sel_addr = AclAddr;
        w_sel_data = AclData;
      end
      M_DMA: begin
        w_sel_we   = DMAWrEn;
        w_sel_addr = DMAAddr;
        w_sel_data = DMAData;
      end
      default: ;
    endcase
  end

  // Byte-offset bits and bits above the RAM range are dropped: misaligned
  // addresses hit the containing word and large addresses wrap.
  assign w_unused = &{1'b0, w_sel_addr[N-1:AW+2], w_sel_addr[1:0]};

  assign w_ram_en = (r_state == S_ACCESS);

  arb_sram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (r_we),
    .addr (r_idx),
    .din  (r_data),
    .dout (w_ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= M_DMA;
      r_win   <= M_CPU;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_out[i] <= '0;
    end else begin
      r_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_win   <= w_sel;
            r_last  <= w_sel;
            r_we    <= w_sel_we;
            r_idx   <= w_sel_addr[AW+1:2];
            r_data  <= w_sel_data;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP: begin
          // RAM output already reflects write data on writes, so one path serves both.
          r_valid[r_win] <= 1'b1;
          r_out[r_win]   <= w_ram_dout;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign CPUOut   = r_out[M_CPU];
  assign AclOut   = r_out[M_ACL];
  assign DMAOut   = r_out[M_DMA];
  assign CPUValid = r_valid[M_CPU];
  assign AclValid = r_valid[M_ACL];
  assign DMAValid = r_valid[M_DMA];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: writes, round-robin order,
// address wrap, dropped enable, mid-operation reset and fairness.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CPUEn = 0, AclEn = 0, DMAEn = 0;
  logic        CPUWrEn = 0, AclWrEn = 0, DMAWrEn = 0;
  logic [31:0] CPUAddr = 0, AclAddr = 0, DMAAddr = 0;
  logic [31:0] CPUData = 0, AclData = 0, DMAData = 0;
  logic [31:0] CPUOut, AclOut, DMAOut;
  logic        CPUValid, AclValid, DMAValid, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N(32), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .CPUEn(CPUEn), .AclEn(AclEn), .DMAEn(DMAEn),
    .CPUWrEn(CPUWrEn), .AclWrEn(AclWrEn), .DMAWrEn(DMAWrEn),
    .CPUAddr(CPUAddr), .AclAddr(AclAddr), .DMAAddr(DMAAddr),
    .CPUData(CPUData), .AclData(AclData), .DMAData(DMAData),
    .CPUOut(CPUOut), .AclOut(AclOut), .DMAOut(DMAOut),
    .CPUValid(CPUValid), .AclValid(AclValid), .DMAValid(DMAValid),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_of(input int m);
    case (m)
      0:       return CPUOut;
      1:       return AclOut;
      default: return DMAOut;
    endcase
  endfunction

  task automatic set_req(input int m, input logic en, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    case (m)
      0: begin CPUEn = en; CPUWrEn = we; CPUAddr = addr; CPUData = data; end
      1: begin AclEn = en; AclWrEn = we; AclAddr = addr; AclData = data; end
      default: begin DMAEn = en; DMAWrEn = we; DMAAddr = addr; DMAData = data; end
    endcase
  endtask

  // One isolated transaction from master m, checked cycle by cycle.
  task automatic run_one(input string tag, input int m, input logic we,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp);
    set_req(m, 1'b1, we, addr, data);
    tick();
    check({tag, "_busy_access"}, {31'b0, busy}, 32'd1);
    check({tag, "_valid_access"}, {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    tick();
    check({tag, "_valid_resp"}, {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    tick();
    check({tag, "_valid"}, {29'b0, DMAValid, AclValid, CPUValid}, 32'd1 << m);
    check({tag, "_out"}, out_of(m), exp);
    check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    $display("txn %s: master %0d we %0b addr %h out %h", tag, m, we, addr, out_of(m));
    set_req(m, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check({tag, "_valid_drop"}, {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_v;
    logic [31:0] exp_d [3];

    tick();
    tick();
    check("rst_valid", {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cpuout", CPUOut, 32'd0);
    check("rst_aclout", AclOut, 32'd0);
    check("rst_dmaout", DMAOut, 32'd0);
    rst_n = 1'b1;
    tick();

    run_one("cpu_wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
    run_one("cpu_rd10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    run_one("cpu_wr14", 0, 1'b1, 32'h14, 32'hA5A50001, 32'hA5A50001);
    run_one("cpu_wr18", 0, 1'b1, 32'h18, 32'h5A5A0002, 32'h5A5A0002);

    // Simultaneous reads from reset: CPU, Acl, DMA at cycles 2, 5, 8.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_d[0] = 32'hDEADBEEF;
    exp_d[1] = 32'hA5A50001;
    exp_d[2] = 32'h5A5A0002;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h18, 32'h0);
    for (int c = 0; c < 9; c++) begin
      tick();
      check($sformatf("sim_busy_c%0d", c), {31'b0, busy}, (c % 3 != 2) ? 32'd1 : 32'd0);
      exp_v = (c == 2) ? 32'd1 : (c == 5) ? 32'd2 : (c == 8) ? 32'd4 : 32'd0;
      check($sformatf("sim_valid_c%0d", c), {29'b0, DMAValid, AclValid, CPUValid}, exp_v);
      if (c % 3 == 2) begin
        check($sformatf("sim_out_m%0d", c / 3), out_of(c / 3), exp_d[c / 3]);
        $display("txn sim: master %0d out %h at cycle %0d", c / 3, out_of(c / 3), c);
        set_req(c / 3, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    tick();
    check("sim_idle_busy", {31'b0, busy}, 32'd0);

    // Address wrap and misalignment: 4*DEPTH+3 aliases word 0.
    run_one("acl_wr_wrap", 1, 1'b1, 32'h1003, 32'h12345678, 32'h12345678);
    run_one("dma_rd0", 2, 1'b0, 32'h0, 32'h0, 32'h12345678);
    check("wrap_aclout_hold", AclOut, 32'h12345678);
    check("wrap_cpuout_hold", CPUOut, 32'hDEADBEEF);

    // DMA enable for a single cycle still completes exactly once.
    set_req(2, 1'b1, 1'b0, 32'h18, 32'h0);
    tick();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("drop_valid_resp", {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    tick();
    check("drop_valid", {29'b0, DMAValid, AclValid, CPUValid}, 32'd4);
    check("drop_out", DMAOut, 32'h5A5A0002);
    $display("txn drop: master 2 out %h", DMAOut);
    tick();
    check("drop_busy_after", {31'b0, busy}, 32'd0);
    tick();
    tick();
    tick();
    check("drop_no_second", {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    check("drop_no_second_busy", {31'b0, busy}, 32'd0);

    // Reset during ACCESS of a CPU read.
    set_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    check("mid_busy_access", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    check("mid_cpuout", CPUOut, 32'd0);
    check("mid_aclout", AclOut, 32'd0);
    check("mid_dmaout", DMAOut, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    $display("txn midreset: outputs cleared");
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("mid_no_valid", {29'b0, DMAValid, AclValid, CPUValid}, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h18, 32'h0);
    tick();
    tick();
    tick();
    check("post_first_cpu", {29'b0, DMAValid, AclValid, CPUValid}, 32'd1);
    check("post_cpuout", CPUOut, 32'hA5A50001);
    $display("txn postreset: master 0 out %h", CPUOut);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    check("post_then_acl", {29'b0, DMAValid, AclValid, CPUValid}, 32'd2);
    check("post_aclout", AclOut, 32'h5A5A0002);
    $display("txn postreset: master 1 out %h", AclOut);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Fairness: CPU and DMA held continuously alternate.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h18, 32'h0);
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_v = (c == 2 || c == 8) ? 32'd1 : (c == 5 || c == 11) ? 32'd4 : 32'd0;
      check($sformatf("fair_valid_c%0d", c), {29'b0, DMAValid, AclValid, CPUValid}, exp_v);
      if (c == 2) check("fair_cpuout", CPUOut, 32'hDEADBEEF);
      if (c == 5) check("fair_dmaout", DMAOut, 32'h5A5A0002);
      if (exp_v != 0) $display("txn fair: valid %b at cycle %0d", exp_v[2:0], c);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
